// File: rtl/uart_frame_loader_if.sv
// Byte-stream, read-port and status bundle of the UART frame loader.
// The design side uses the slave modport; the producer/reader uses master.
interface uart_frame_loader_if;
    logic [7:0]  byte_in;
    logic        byte_stb;
    logic [7:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        frame_ok;
    logic        frame_err;
    logic        busy;
    logic [15:0] frame_cnt;

    modport master (
        output byte_in, byte_stb, rd_addr,
        input  rd_data, frame_ok, frame_err, busy, frame_cnt
    );

    modport slave (
        input  byte_in, byte_stb, rd_addr,
        output rd_data, frame_ok, frame_err, busy, frame_cnt
    );
endinterface

// File: rtl/uart_frame_loader.sv
// Header-framed, checksummed payload loader into a double-buffered parameter RAM.
// Optional macro UART_TIMEOUT_EN adds an inter-byte timeout that aborts partial frames.
module uart_frame_loader #(
    parameter int         FRAME_LEN   = 112,
    parameter logic [7:0] HEADER      = 8'hA5
`ifdef UART_TIMEOUT_EN
    , parameter int       TIMEOUT_CYC = 20000
`endif
) (
    input logic               clk,
    input logic               rst_n,
    uart_frame_loader_if.slave bus
);

    localparam int         AW   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [7:0] LAST = 8'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK} state_t;

    state_t     state;
    logic [7:0] wr_ptr;
    logic [7:0] sum;
    logic       active;
    logic       timeout_hit;

    logic [7:0] mem [2][FRAME_LEN];

`ifdef UART_TIMEOUT_EN
    localparam int            TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] LIMIT_M1 = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] idle_cnt;

    // The timeout fires on the edge where the counter would reach the limit,
    // and it overrides any strobe arriving in that same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (bus.byte_stb || state == IDLE || timeout_hit) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + TW'(1);
        end
    end

    assign timeout_hit = (state != IDLE) && (idle_cnt == LIMIT_M1);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            wr_ptr        <= 8'd0;
            sum           <= 8'd0;
            active        <= 1'b0;
            bus.frame_ok  <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.busy      <= 1'b0;
            bus.frame_cnt <= 16'd0;
        end else begin
            bus.frame_ok  <= 1'b0;
            bus.frame_err <= 1'b0;
            if (timeout_hit) begin
                state         <= IDLE;
                bus.busy      <= 1'b0;
                bus.frame_err <= 1'b1;
            end else if (bus.byte_stb) begin
                case (state)
                    IDLE: begin
                        if (bus.byte_in == HEADER) begin
                            state    <= PAYLOAD;
                            wr_ptr   <= 8'd0;
                            sum      <= 8'd0;
                            bus.busy <= 1'b1;
                        end
                    end
                    PAYLOAD: begin
                        sum    <= sum + bus.byte_in;
                        wr_ptr <= wr_ptr + 8'd1;
                        if (wr_ptr == LAST) begin
                            state <= CHECK;
                        end
                    end
                    CHECK: begin
                        // Swapping banks only on a good checksum keeps the reader on a whole frame.
                        if (bus.byte_in == sum) begin
                            active        <= ~active;
                            bus.frame_ok  <= 1'b1;
                            bus.frame_cnt <= bus.frame_cnt + 16'd1;
                        end else begin
                            bus.frame_err <= 1'b1;
                        end
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == PAYLOAD && bus.byte_stb && !timeout_hit) begin
            mem[~active][wr_ptr[AW-1:0]] <= bus.byte_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rd_data <= 8'h00;
        end else if (bus.rd_addr <= LAST) begin
            bus.rd_data <= mem[active][bus.rd_addr[AW-1:0]];
        end else begin
            bus.rd_data <= 8'h00;
        end
    end

endmodule
